alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined ALU. Successor to the fixed-width single-cycle ALU.
- Adds a valid/ready handshake on the input and output sides, back-pressure stalling, a zero flag, and defined carry/borrow semantics for shifts.
- Sits behind the verification interface wrapper, driven by the bench.

---
 rtl/alu_pipe.sv | 137 +++++++++++++
 tb/tb_alu_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: s1 holds operands, s2 holds the result and drives the outputs.
// Optional ov_out (signed overflow) is enabled by defining ALU_OVF_EN.
module alu_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             co_out,
`ifdef ALU_OVF_EN
    output logic             ov_out,
`endif
    output logic             zero_out
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] a_q, b_q;
    op_e              op_q;
    logic [WIDTH-1:0] y_q, y_d;
    logic             co_q, co_d;
    logic             zero_q, zero_d;
`ifdef ALU_OVF_EN
    logic             ov_q, ov_d;
`endif

    logic             s2_adv, s1_adv, in_fire;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum, diff, shl_w, shr_w;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // Widened operands put the carry/borrow/shift-out bit in the extra MSB (or LSB for SHR),
    // which also yields co=0 naturally for a zero shift amount.
    assign sh    = b_q[SHW-1:0];
    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign shl_w = {1'b0, a_q} << sh;
    assign shr_w = {a_q, 1'b0} >> sh;

    always_comb begin
        y_d  = '0;
        co_d = 1'b0;
        unique case (op_q)
            OP_ADD:  {co_d, y_d} = sum;
            OP_SUB:  {co_d, y_d} = diff;
            OP_AND:  y_d = a_q & b_q;
            OP_OR:   y_d = a_q | b_q;
            OP_XOR:  y_d = a_q ^ b_q;
            OP_SHL:  {co_d, y_d} = shl_w;
            OP_SHR:  begin y_d = shr_w[WIDTH:1]; co_d = shr_w[0]; end
            OP_PASS: y_d = a_q;
            default: y_d = a_q;
        endcase
        zero_d = (y_d == '0);
    end

`ifdef ALU_OVF_EN
    always_comb begin
        ov_d = 1'b0;
        if (op_q == OP_ADD)
            ov_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
        else if (op_q == OP_SUB)
            ov_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_fire) begin
                a_q  <= a_in;
                b_q  <= b_in;
                op_q <= op_e'(op_in);
            end
        end
    end

    // s2 data only changes on a real advance, so results hold during a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            co_q       <= 1'b0;
            zero_q     <= 1'b0;
`ifdef ALU_OVF_EN
            ov_q       <= 1'b0;
`endif
        end else begin
            if (s2_adv)
                s2_valid_q <= s1_valid_q;
            if (s1_adv) begin
                y_q    <= y_d;
                co_q   <= co_d;
                zero_q <= zero_d;
`ifdef ALU_OVF_EN
                ov_q   <= ov_d;
`endif
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign y_out     = y_q;
    assign co_out    = co_q;
    assign zero_out  = zero_q;
`ifdef ALU_OVF_EN
    assign ov_out    = ov_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal cases, back-pressure, reset flush, then random traffic
// scored against an arithmetic model through an in-order expectation queue.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   op_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] y_out;
    logic         co_out;
    logic         zero_out;
    logic         ov_out;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .co_out(co_out),
`ifdef ALU_OVF_EN
        .ov_out(ov_out),
`endif
        .zero_out(zero_out)
    );
`ifndef ALU_OVF_EN
    assign ov_out = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int y;
        int co;
        int ov;
    } res_t;

    function automatic res_t model(input int a, input int b, input int op);
        res_t r;
        int mask = (1 << W) - 1;
        int sh = b % W;
        int s;
        int sa = (a >> (W - 1)) & 1;
        int sb = (b >> (W - 1)) & 1;
        r.co = 0;
        r.ov = 0;
        case (op)
            0: begin s = a + b; r.y = s & mask; r.co = s >> W; end
            1: begin r.y = (a - b) & mask; r.co = (a < b) ? 1 : 0; end
            2: r.y = a & b;
            3: r.y = a | b;
            4: r.y = a ^ b;
            5: begin r.y = (a << sh) & mask; r.co = (sh == 0) ? 0 : (a >> (W - sh)) & 1; end
            6: begin r.y = a >> sh; r.co = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
            default: r.y = a;
        endcase
        if (op == 0) r.ov = (sa == sb && ((r.y >> (W - 1)) & 1) != sa) ? 1 : 0;
        if (op == 1) r.ov = (sa != sb && ((r.y >> (W - 1)) & 1) != sa) ? 1 : 0;
        return r;
    endfunction

    res_t         exp_q[$];
    bit           stall_q = 0;
    logic [W-1:0] hold_y;
    logic         hold_co, hold_z, hold_ov;

    // Scoreboard: samples at negedge, away from the active edge.
    always @(negedge clk) begin
        res_t e;
        if (!reset) begin
            exp_q.delete();
            stall_q = 0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_y", 32'(y_out), 32'(hold_y));
                chk("hold_co", 32'(co_out), 32'(hold_co));
                chk("hold_zero", 32'(zero_out), 32'(hold_z));
                chk("hold_ov", 32'(ov_out), 32'(hold_ov));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_y", 32'(y_out), 32'(e.y));
                    chk("sb_co", 32'(co_out), 32'(e.co));
                    chk("sb_zero", 32'(zero_out), (e.y == 0) ? 32'd1 : 32'd0);
`ifdef ALU_OVF_EN
                    chk("sb_ov", 32'(ov_out), 32'(e.ov));
`endif
                end
            end
            stall_q = out_valid && !out_ready;
            hold_y  = y_out;
            hold_co = co_out;
            hold_z  = zero_out;
            hold_ov = ov_out;
            if (in_valid && in_ready)
                exp_q.push_back(model(int'(a_in), int'(b_in), int'(op_in)));
        end
    end

    // Single beat into an empty pipe with out_ready=1; checks 2-cycle latency and 1-cycle valid.
    // Entered and left at posedge+1.
    task automatic dir(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic [W-1:0] ey, input logic eco,
                       input logic ez, input logic eov);
        out_ready = 1'b1;
        in_valid = 1'b1; a_in = a; b_in = b; op_in = op;
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
        chk({nm, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_vld"}, 32'(out_valid), 32'd1);
        chk({nm, "_y"}, 32'(y_out), 32'(ey));
        chk({nm, "_co"}, 32'(co_out), 32'(eco));
        chk({nm, "_zero"}, 32'(zero_out), 32'(ez));
`ifdef ALU_OVF_EN
        chk({nm, "_ov"}, 32'(ov_out), 32'(eov));
`else
        if (eov) ;
`endif
        @(negedge clk);
        chk({nm, "_once"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit took;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_co", 32'(co_out), 32'd0);
        chk("rst_zero", 32'(zero_out), 32'd0);
        chk("rst_ov", 32'(ov_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed literal cases
        dir("add_ff_01", 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0);
        dir("sub_10_20", 8'h10, 8'h20, 3'b001, 8'hF0, 1'b1, 1'b0, 1'b0);
        dir("sub_20_10", 8'h20, 8'h10, 3'b001, 8'h10, 1'b0, 1'b0, 1'b0);
        dir("shl_81_1",  8'h81, 8'h01, 3'b101, 8'h02, 1'b1, 1'b0, 1'b0);
        dir("shr_81_1",  8'h81, 8'h01, 3'b110, 8'h40, 1'b1, 1'b0, 1'b0);
        dir("shl_81_0",  8'h81, 8'h00, 3'b101, 8'h81, 1'b0, 1'b0, 1'b0);
        dir("shr_80_7",  8'h80, 8'h07, 3'b110, 8'h01, 1'b0, 1'b0, 1'b0);
        dir("xor_zero",  8'h5A, 8'h5A, 3'b100, 8'h00, 1'b0, 1'b1, 1'b0);
        dir("ov_add",    8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b1);
        dir("ov_sub",    8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b0, 1'b1);
        dir("ov_and",    8'hFF, 8'hFF, 3'b010, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Back-pressure: two beats fill the pipe, the third waits
        out_ready = 1'b0;
        in_valid = 1'b1; a_in = 8'h01; b_in = 8'h02; op_in = 3'b000;
        @(negedge clk); chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk); #1; a_in = 8'h10; b_in = 8'h20;
        @(negedge clk); chk("bp_rdy2", 32'(in_ready), 32'd1);
        @(posedge clk); #1; a_in = 8'h40; b_in = 8'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_full", 32'(in_ready), 32'd0);
            chk("bp_y1", 32'(y_out), 32'h03);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_rdy", 32'(in_ready), 32'd1);
        chk("bp_o1", 32'(y_out), 32'h03);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_o2v", 32'(out_valid), 32'd1);
        chk("bp_o2", 32'(y_out), 32'h30);
        @(negedge clk);
        chk("bp_o3v", 32'(out_valid), 32'd1);
        chk("bp_o3", 32'(y_out), 32'h80);
        @(negedge clk);
        chk("bp_done", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a_in = 8'h11; b_in = 8'h22; op_in = 3'b000;
        @(posedge clk); #1; a_in = 8'h33; b_in = 8'h44;
        @(posedge clk); #1; in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(y_out), 32'd0);
        chk("mid_rst_co", 32'(co_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Random traffic; source holds a beat until it is taken
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a_in  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                b_in  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                op_in = 3'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
